// File: rtl/rx_tx_pkg.sv
// Shared encodings for the dual-rail transmit (merge) node.
package rx_tx_pkg;

  localparam logic [1:0] DR_NULL = 2'b00;
  localparam logic [1:0] DR_ZERO = 2'b01;
  localparam logic [1:0] DR_ONE  = 2'b10;
  localparam logic [1:0] DR_ILL  = 2'b11;

  localparam logic [1:0] HDR_C0 = DR_ZERO;
  localparam logic [1:0] HDR_C1 = DR_ONE;

  typedef enum logic [2:0] {
    IDLE,
    HDR_UP,
    HDR_DN,
    CH_WAIT,
    CH_ACK,
    P_UP,
    P_DN
  } tx_state_t;

  function automatic logic [1:0] hdr_of(input logic sel);
    return sel ? HDR_C1 : HDR_C0;
  endfunction

endpackage

// File: rtl/rx_tx_sync.sv
// Multi-flop synchronizer for asynchronous handshake signals; resets to zero.
module rx_tx_sync #(
  parameter int unsigned W      = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [STAGES-1:0][W-1:0] chain_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/rx_tx_node.sv
// Merges two dual-rail 4-phase child channels into one parent channel,
// prefixing each PKT_LEN-token packet with a route token naming the source child.
module rx_tx_node
  import rx_tx_pkg::*;
#(
  parameter int unsigned PKT_LEN     = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       c0r,
  input  logic [1:0] c0d,
  output logic       c0a,
  input  logic       c1r,
  input  logic [1:0] c1d,
  output logic       c1a,
  output logic       pr,
  output logic [1:0] pd,
  input  logic       pa,
  output logic       err
);

  localparam int unsigned CW = $clog2(PKT_LEN + 1);

  logic       c0r_s, c1r_s, pa_s;
  logic [1:0] c0d_s, c1d_s;

  rx_tx_sync #(.W(1), .STAGES(SYNC_STAGES)) u_sync_c0r (.clk(clk), .rstn(rstn), .d_i(c0r), .q_o(c0r_s));
  rx_tx_sync #(.W(1), .STAGES(SYNC_STAGES)) u_sync_c1r (.clk(clk), .rstn(rstn), .d_i(c1r), .q_o(c1r_s));
  rx_tx_sync #(.W(1), .STAGES(SYNC_STAGES)) u_sync_pa  (.clk(clk), .rstn(rstn), .d_i(pa),  .q_o(pa_s));
  rx_tx_sync #(.W(2), .STAGES(SYNC_STAGES)) u_sync_c0d (.clk(clk), .rstn(rstn), .d_i(c0d), .q_o(c0d_s));
  rx_tx_sync #(.W(2), .STAGES(SYNC_STAGES)) u_sync_c1d (.clk(clk), .rstn(rstn), .d_i(c1d), .q_o(c1d_s));

  tx_state_t   state_q, state_d;
  logic        sel_q, sel_d;
  logic        last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]  tok_q, tok_d;
  logic        pr_q, pr_d;
  logic [1:0]  pd_q, pd_d;
  logic        c0a_q, c0a_d;
  logic        c1a_q, c1a_d;
  logic        err_q, err_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      tok_q   <= DR_NULL;
      pr_q    <= 1'b0;
      pd_q    <= DR_NULL;
      c0a_q   <= 1'b0;
      c1a_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tok_q   <= tok_d;
      pr_q    <= pr_d;
      pd_q    <= pd_d;
      c0a_q   <= c0a_d;
      c1a_q   <= c1a_d;
      err_q   <= err_d;
    end
  end

  logic       win;
  logic       req_sel;
  logic [1:0] dat_sel;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    tok_d   = tok_q;
    pr_d    = pr_q;
    pd_d    = pd_q;
    c0a_d   = c0a_q;
    c1a_d   = c1a_q;
    err_d   = err_q;
    win     = 1'b0;
    req_sel = sel_q ? c1r_s : c0r_s;
    dat_sel = sel_q ? c1d_s : c0d_s;

    case (state_q)
      IDLE: begin
        if (c0r_s || c1r_s) begin
          // Tie goes to the child that was not served last.
          win     = (c0r_s && c1r_s) ? ~last_q : c1r_s;
          sel_d   = win;
          last_d  = win;
          pd_d    = hdr_of(win);
          pr_d    = 1'b1;
          state_d = HDR_UP;
        end
      end
      HDR_UP: begin
        if (pa_s) begin
          pr_d    = 1'b0;
          pd_d    = DR_NULL;
          state_d = HDR_DN;
        end
      end
      HDR_DN: begin
        if (!pa_s) state_d = CH_WAIT;
      end
      CH_WAIT: begin
        if (req_sel && (dat_sel != DR_NULL)) begin
          if (dat_sel == DR_ILL) begin
            err_d = 1'b1;
            tok_d = DR_ZERO;
          end else begin
            tok_d = dat_sel;
          end
          if (sel_q) c1a_d = 1'b1;
          else       c0a_d = 1'b1;
          state_d = CH_ACK;
        end
      end
      CH_ACK: begin
        if (!req_sel && (dat_sel == DR_NULL)) begin
          c0a_d   = 1'b0;
          c1a_d   = 1'b0;
          pd_d    = tok_q;
          pr_d    = 1'b1;
          state_d = P_UP;
        end
      end
      P_UP: begin
        if (pa_s) begin
          pr_d    = 1'b0;
          pd_d    = DR_NULL;
          cnt_d   = cnt_q + 1'b1;
          state_d = P_DN;
        end
      end
      P_DN: begin
        if (!pa_s) begin
          if (cnt_q == CW'(PKT_LEN)) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            state_d = CH_WAIT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign c0a = c0a_q;
  assign c1a = c1a_q;
  assign pr  = pr_q;
  assign pd  = pd_q;
  assign err = err_q;

endmodule
